// File: rtl/mem_port_arbiter_if.sv
// CPU-side (I and D ports) and memory-side signals of mem_port_arbiter.
// The arbiter uses the slave view; the environment (cpu + memory) uses the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_re;
    logic          m_we;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output m_addr, m_wdata, m_re, m_we
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_addr, m_wdata, m_re, m_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported synchronous-read memory between
// the CPU instruction-fetch port (read-only) and data port (read/write).
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int RD_LATENCY = 1
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    // Handshake: a requester raises x_req with stable fields and holds them until it
    // sees x_gnt high in the same cycle; that cycle is the transfer. Read responses
    // arrive on x_rvalid/x_rdata exactly RD_LATENCY cycles later and cannot be stalled.

    logic          last_grant;    // 0 = I won last, 1 = D won last
    logic          grant_i;
    logic          grant_d;
    logic          push_valid;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Response tracking: index 0 is the newest entry, RD_LATENCY-1 is the tail.
    logic [RD_LATENCY-1:0] trk_valid;
    logic [RD_LATENCY-1:0] trk_port;

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst) begin
            if (bus.i_req && bus.d_req) begin
                grant_i = last_grant;
                grant_d = ~last_grant;
            end else begin
                grant_i = bus.i_req;
                grant_d = bus.d_req;
            end
        end
    end

    always_comb begin
        sel_addr   = grant_d ? bus.d_addr : bus.i_addr;
        sel_wdata  = bus.d_wdata;
        push_valid = grant_i | (grant_d & ~bus.d_we);
    end

    assign bus.i_gnt   = grant_i;
    assign bus.d_gnt   = grant_d;
    assign bus.m_addr  = sel_addr;
    assign bus.m_wdata = sel_wdata;
    assign bus.m_re    = push_valid;
    assign bus.m_we    = grant_d & bus.d_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            trk_valid  <= '0;
            trk_port   <= '0;
        end else begin
            if (grant_i || grant_d) begin
                last_grant <= grant_d;
            end
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                trk_valid[i] <= trk_valid[i-1];
                trk_port[i]  <= trk_port[i-1];
            end
            trk_valid[0] <= push_valid;
            trk_port[0]  <= grant_d;
        end
    end

    // Reads still in flight while rst is high are suppressed, not delivered.
    assign bus.i_rvalid = ~rst & trk_valid[RD_LATENCY-1] & ~trk_port[RD_LATENCY-1];
    assign bus.d_rvalid = ~rst & trk_valid[RD_LATENCY-1] &  trk_port[RD_LATENCY-1];
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives two arbiters (read latency 1 and 3) with identical stimulus, each backed by its
// own memory model, and checks both against one request/response reference model.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;

    mem_port_arbiter_if #(.AW(16), .DW(16)) bus1 ();
    mem_port_arbiter_if #(.AW(16), .DW(16)) bus3 ();

    mem_port_arbiter #(.AW(16), .DW(16), .RD_LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );
    mem_port_arbiter #(.AW(16), .DW(16), .RD_LATENCY(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory models ----------------
    logic [15:0] mem1 [0:65535];
    logic [15:0] mem3 [0:65535];
    logic [15:0] p1;
    logic [15:0] p3a, p3b, p3c;

    always @(posedge clk) begin
        p1 <= bus1.m_re ? mem1[bus1.m_addr] : 16'hDEAD;
        if (bus1.m_we) mem1[bus1.m_addr] = bus1.m_wdata;
    end
    always @(posedge clk) begin
        p3a <= bus3.m_re ? mem3[bus3.m_addr] : 16'hDEAD;
        p3b <= p3a;
        p3c <= p3b;
        if (bus3.m_we) mem3[bus3.m_addr] = bus3.m_wdata;
    end
    assign bus1.m_rdata = p1;
    assign bus3.m_rdata = p3c;

    // ---------------- reference model state ----------------
    logic [15:0] ref_mem [0:65535];
    logic [48:0] exp_q1[$];   // {due_cycle[31:0], port(1=D), data[15:0]}
    logic [48:0] exp_q3[$];
    logic        lg;          // 1 = D was last winner
    int          cyc;
    int          checks;
    int          errors;

    logic        cur_rst, cur_ir, cur_dr, cur_dwe;
    logic [15:0] cur_ia, cur_da, cur_dwd;
    logic        eg_i, eg_d;
    logic        obs_dg1;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_inst(input int k, input string nm,
                              input logic ig, input logic dg, input logic mre, input logic mwe,
                              input logic [15:0] maddr, input logic [15:0] mwdata,
                              input logic irv, input logic [15:0] ird,
                              input logic drv, input logic [15:0] drd);
        logic [48:0] h;
        bit          have;
        bit          due;
        logic        eirv, edrv;
        if (k == 0) begin
            have = exp_q1.size() != 0;
            h    = have ? exp_q1[0] : '0;
        end else begin
            have = exp_q3.size() != 0;
            h    = have ? exp_q3[0] : '0;
        end
        due  = have && (int'(h[48:17]) == cyc);
        eirv = !cur_rst && due && !h[16];
        edrv = !cur_rst && due &&  h[16];

        chk({nm, ".i_gnt"}, 16'(ig), 16'(eg_i));
        chk({nm, ".d_gnt"}, 16'(dg), 16'(eg_d));
        chk({nm, ".gnt_excl"}, 16'(ig & dg), 16'd0);
        chk({nm, ".m_re"}, 16'(mre), 16'(eg_i | (eg_d & ~cur_dwe)));
        chk({nm, ".m_we"}, 16'(mwe), 16'(eg_d & cur_dwe));
        chk({nm, ".re_we_excl"}, 16'(mre & mwe), 16'd0);
        if (eg_i) chk({nm, ".m_addr_i"}, maddr, cur_ia);
        if (eg_d) chk({nm, ".m_addr_d"}, maddr, cur_da);
        if (eg_d && cur_dwe) chk({nm, ".m_wdata"}, mwdata, cur_dwd);
        chk({nm, ".i_rvalid"}, 16'(irv), 16'(eirv));
        chk({nm, ".d_rvalid"}, 16'(drv), 16'(edrv));
        if (eirv) chk({nm, ".i_rdata"}, ird, h[15:0]);
        if (edrv) chk({nm, ".d_rdata"}, drd, h[15:0]);
        if (!cur_rst && due) begin
            if (k == 0) void'(exp_q1.pop_front());
            else        void'(exp_q3.pop_front());
        end
    endtask

    // One clock cycle: drive at posedge+1, check mid-cycle, advance the model after the edge.
    task automatic do_cycle(input logic r, input logic ir, input logic [15:0] ia,
                            input logic dr, input logic dwe, input logic [15:0] da,
                            input logic [15:0] dwd);
        logic [15:0] a;
        cur_rst = r; cur_ir = ir; cur_ia = ia; cur_dr = dr; cur_dwe = dwe; cur_da = da; cur_dwd = dwd;
        rst = r;
        bus1.i_req = ir; bus1.i_addr = ia; bus1.d_req = dr; bus1.d_we = dwe;
        bus1.d_addr = da; bus1.d_wdata = dwd;
        bus3.i_req = ir; bus3.i_addr = ia; bus3.d_req = dr; bus3.d_we = dwe;
        bus3.d_addr = da; bus3.d_wdata = dwd;
        // Round-robin: a lone requester wins; on a tie the port that did not win last wins.
        eg_i = 1'b0;
        eg_d = 1'b0;
        if (!r) begin
            if (ir && dr) begin
                if (lg) eg_i = 1'b1; else eg_d = 1'b1;
            end else begin
                eg_i = ir;
                eg_d = dr;
            end
        end
        #4;
        obs_dg1 = bus1.d_gnt;
        check_inst(0, "L1", bus1.i_gnt, bus1.d_gnt, bus1.m_re, bus1.m_we, bus1.m_addr,
                   bus1.m_wdata, bus1.i_rvalid, bus1.i_rdata, bus1.d_rvalid, bus1.d_rdata);
        check_inst(1, "L3", bus3.i_gnt, bus3.d_gnt, bus3.m_re, bus3.m_we, bus3.m_addr,
                   bus3.m_wdata, bus3.i_rvalid, bus3.i_rdata, bus3.d_rvalid, bus3.d_rdata);
        @(posedge clk);
        #1;
        if (r) begin
            lg = 1'b1;
            exp_q1.delete();
            exp_q3.delete();
        end else if (eg_i || eg_d) begin
            lg = eg_d;
            if (eg_d && dwe) begin
                ref_mem[da] = dwd;
            end else begin
                a = eg_d ? da : ia;
                exp_q1.push_back({32'(cyc + 1), eg_d, ref_mem[a]});
                exp_q3.push_back({32'(cyc + 3), eg_d, ref_mem[a]});
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // ---------------- stimulus ----------------
    logic [3:0]  gseq;
    logic        r_ir, r_dr, r_dwe;
    logic [15:0] r_ia, r_da, r_dwd;

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        lg     = 1'b1;
        for (int a = 0; a < 65536; a++) begin
            mem1[a]    = 16'(32'h1000 + a);
            mem3[a]    = 16'(32'h1000 + a);
            ref_mem[a] = 16'(32'h1000 + a);
        end
        rst = 1'b1;
        bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
        bus1.d_addr = '0; bus1.d_wdata = '0;
        bus3.i_req = 1'b0; bus3.i_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
        bus3.d_addr = '0; bus3.d_wdata = '0;
        @(posedge clk);
        #1;

        // Reset: requests present but nothing granted or issued.
        do_cycle(1'b1, 1'b1, 16'h0, 1'b1, 1'b1, 16'h0, 16'h0);
        do_cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

        // I-only fetch stream 0..3.
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b1, 16'(i), 1'b0, 1'b0, 16'h0, 16'h0);
        idle(4);

        // Fresh reset, then both ports tied for 4 cycles: I,D,I,D.
        do_cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        do_cycle(1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h0010, 16'h0); gseq[0] = obs_dg1;
        do_cycle(1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 16'h0010, 16'h0); gseq[1] = obs_dg1;
        do_cycle(1'b0, 1'b1, 16'h0005, 1'b1, 1'b0, 16'h0010, 16'h0); gseq[2] = obs_dg1;
        do_cycle(1'b0, 1'b1, 16'h0006, 1'b1, 1'b0, 16'h0010, 16'h0); gseq[3] = obs_dg1;
        chk("tie_order", 16'(gseq), 16'b1010);
        idle(4);

        // Write then read-back of the same address.
        do_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 16'hBEEF);
        do_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0);
        idle(4);

        // Back-to-back I, D, I reads.
        do_cycle(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0);
        do_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
        do_cycle(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(4);

        // Two reads, then reset before the L3 data returns; first tie afterwards goes to I.
        do_cycle(1'b0, 1'b1, 16'h0030, 1'b0, 1'b0, 16'h0, 16'h0);
        do_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0031, 16'h0);
        do_cycle(1'b1, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0041, 16'h0);
        do_cycle(1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0041, 16'h0);
        chk("post_reset_tie_d", 16'(obs_dg1), 16'd0);
        do_cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0041, 16'h0);
        idle(5);

        // Random traffic; an ungranted request is held with its fields unchanged.
        r_ir = 1'b0; r_dr = 1'b0; r_dwe = 1'b0; r_ia = '0; r_da = '0; r_dwd = '0;
        for (int n = 0; n < 1000; n++) begin
            if (!(r_ir && !eg_i)) begin
                r_ir = 1'($urandom_range(0, 1));
                r_ia = 16'(16'h0050 + $urandom_range(0, 15));
            end
            if (!(r_dr && !eg_d)) begin
                r_dr  = 1'($urandom_range(0, 1));
                r_dwe = 1'($urandom_range(0, 1));
                r_da  = 16'(16'h0050 + $urandom_range(0, 15));
                r_dwd = 16'($urandom);
            end
            do_cycle(1'b0, r_ir, r_ia, r_dr, r_dwe, r_da, r_dwd);
        end
        idle(6);
        chk("drain_l1", 16'(exp_q1.size()), 16'd0);
        chk("drain_l3", 16'(exp_q3.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
